vga_timing_gen: RTL

Pixel-timing generator for the 640x480 @ 60 Hz display path. It runs on the VGA pixel clock and produces the DrawX/DrawY pixel coordinates, the active-video `blank` qualifier and the hs/vs sync pulses. Every sprite and screen renderer downstream consumes these outputs, including the full-screen result display, which registers its RGB one cycle after each coordinate. It also provides a frame-start pulse and a frame counter for game logic and animation.

---
 rtl/vga_timing_gen.sv | 106 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel-timing generator: counters, blank/sync/frame decode, all registered from next-state counts.
// Optional VGA_SYNC_DELAY_EN adds one register stage to hs/vs to line them up with a registered RGB path.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fs_q, fs_d;
  logic [7:0] fc_q, fc_d;

  // Decode from the next-state counts so every output flips on the same edge as the counters.
  always_comb begin
    hc_d = (hc_q == H_MAX) ? '0 : hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_MAX) begin
      vc_d = (vc_q == V_MAX) ? '0 : vc_q + 10'd1;
    end
    blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
    hs_d    = !((hc_d >= HS_BEG) && (hc_d < HS_END));
    vs_d    = !((vc_d >= VS_BEG) && (vc_d < VS_END));
    fs_d    = (hc_d == '0) && (vc_d == '0);
    fc_d    = fs_d ? fc_q + 8'd1 : fc_q;
  end

  // Reset state is the decode of the last position of a frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= H_MAX;
      vc_q    <= V_MAX;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_dly_q;
  logic vs_dly_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly_q <= 1'b1;
      vs_dly_q <= 1'b1;
    end else begin
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
    end
  end

  assign hs = hs_dly_q;
  assign vs = vs_dly_q;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule
